pos_cache_mu_ctrl: RTL and testbench
====================================

POS_CACHE_MU_CTRL -- requirements
Module: pos_cache_mu_ctrl

Interface
REQ-001 Parameters, one per line: NUM_CELLS 64 total cells (4x4x4); CELL_ID_WIDTH 3 per-axis cell id width; PARTICLE_ID_WIDTH 7 particle address width; NUM_PARTICLE_PER_CELL 128 cache depth; CREDITS 4 motion-update input FIFO depth.
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are listed first; one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse, begins motion-update pass; ignored unless IDLE.
REQ-006 cnt_rd_cell  out  full_cell_id_t  cell whose particle count is requested.
REQ-007 cnt_rd_en  out  1  particle-count lookup strobe; data returns next cycle.
REQ-008 cnt_rd_data  in  PARTICLE_ID_WIDTH+1  particle count of the requested cell, 0..NUM_PARTICLE_PER_CELL.
REQ-009 Motion_Update_enable  out  1  high from pass start until done; drives cache write-select mode.
REQ-010 MU_rden  out  1  position-cache read strobe.
REQ-011 MU_rd_addr  out  PARTICLE_ID_WIDTH  particle address for the read.
REQ-012 MU_rd_cell  out  full_cell_id_t  home cell of the read.
REQ-013 mu_consume  in  1  pulse: motion-update unit popped one entry from its input FIFO (returns one credit).
REQ-014 MU_wr_data_valid  in  1  motion-update unit writes one particle back (any destination cell).
REQ-015 busy  out  1  high outside IDLE.
REQ-016 done  out  1  one-cycle pulse at pass completion.

Function
REQ-017 States: IDLE, CNT_REQ, CNT_WAIT, READ, NEXT_CELL, DRAIN, DONE.
REQ-018 IDLE->CNT_REQ on start; cell pointer = (1,1,1), read/write counters cleared, credits = CREDITS.
REQ-019 CNT_REQ: cnt_rd_en=1 for one cycle with cnt_rd_cell = pointer; -> CNT_WAIT.
REQ-020 CNT_WAIT: latch cnt_rd_data as cell limit; limit 0 -> NEXT_CELL, else READ with particle address 0.
REQ-021 READ: MU_rden=1 only when credits>0; each issued read increments address and total-read counter, decrements credit; after address = limit-1 issued -> NEXT_CELL.
REQ-022 Credit counter width clog2(CREDITS+1); mu_consume increments; simultaneous issue and consume leaves credits unchanged; credits never exceed CREDITS nor go below 0.
REQ-023 NEXT_CELL: advance pointer x fastest, then y, then z, each 1..4 wrapping; after (4,4,4) -> DRAIN, else CNT_REQ.
REQ-024 Total-read and write counters width clog2(NUM_CELLS*NUM_PARTICLE_PER_CELL+1); MU_wr_data_valid increments write counter in any non-IDLE state.
REQ-025 DRAIN: wait until write counter equals total-read counter -> DONE.
REQ-026 DONE: done=1 one cycle, Motion_Update_enable falls same cycle as done is low next; -> IDLE.
REQ-027 Motion_Update_enable =1 in all states except IDLE; busy identical.
REQ-028 MU_rd_addr, MU_rd_cell registered; valid exactly when MU_rden=1.
REQ-029 start while busy ignored; MU_wr_data_valid in IDLE ignored.

Reset
REQ-030 rst asserted any cycle, including mid-pass: state IDLE, all outputs 0, MU_rd_cell and cnt_rd_cell = (1,1,1), counters 0, credits CREDITS; no done pulse.

Structure
REQ-031 full_cell_id_t and offset_tuple_t from md_pkg; ctrl state enum and NUM_CELL_PER_AXIS=4 added to md_pkg.
REQ-032 Single sub-module mu_credit_counter (credit tracking); rest flat.

Verification
REQ-033 All counts 0, start -> 64 CNT_REQ lookups, zero MU_rden, done exactly once, Motion_Update_enable low after.
REQ-034 Cell (2,1,1) count 3, others 0, mu_consume every cycle -> MU_rden addresses 0,1,2 with MU_rd_cell (2,1,1); done after 3 MU_wr_data_valid.
REQ-035 Cell (1,1,1) count 10, no mu_consume -> exactly 4 reads then stall; one mu_consume -> one further read next cycle.
REQ-036 Count 128 in (4,4,4), simultaneous issue and consume -> credits constant, addresses 0..127, no address wrap.
REQ-037 rst pulse during READ at address 5 -> all outputs 0 next cycle, new start restarts at (1,1,1) address 0.
REQ-038 Writes held back until DRAIN -> done only after write count equals read count.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the molecular-dynamics cell grid and the motion-update controller.
package md_pkg;

    localparam int unsigned NUM_CELL_PER_AXIS = 4;
    localparam int unsigned CELL_ID_W         = 3;
    localparam int unsigned PARTICLE_ID_W     = 7;

    typedef struct packed {
        logic [CELL_ID_W-1:0] x;
        logic [CELL_ID_W-1:0] y;
        logic [CELL_ID_W-1:0] z;
    } full_cell_id_t;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
        logic [1:0] z;
    } offset_tuple_t;

    typedef enum logic [2:0] {
        StIdle,
        StCntReq,
        StCntWait,
        StRead,
        StNextCell,
        StDrain,
        StDone
    } mu_ctrl_state_e;

    localparam logic [CELL_ID_W-1:0] AXIS_LAST  = CELL_ID_W'(NUM_CELL_PER_AXIS);
    localparam full_cell_id_t        FIRST_CELL = '{x: CELL_ID_W'(1), y: CELL_ID_W'(1),
                                                    z: CELL_ID_W'(1)};

    // Cell ids are 1-based on every axis.
    function automatic logic [CELL_ID_W-1:0] axis_inc(input logic [CELL_ID_W-1:0] v);
        return (v == AXIS_LAST) ? CELL_ID_W'(1) : v + 1'b1;
    endfunction

    function automatic full_cell_id_t next_cell(input full_cell_id_t c);
        full_cell_id_t n;
        n   = c;
        n.x = axis_inc(c.x);
        if (c.x == AXIS_LAST) begin
            n.y = axis_inc(c.y);
            if (c.y == AXIS_LAST) begin
                n.z = axis_inc(c.z);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pos_cache_mu_ctrl_if.sv
// Count-lookup, position-read and motion-update handshake bundle of the controller.
interface pos_cache_mu_ctrl_if;
    import md_pkg::*;

    logic                     start;
    full_cell_id_t            cnt_rd_cell;
    logic                     cnt_rd_en;
    logic [PARTICLE_ID_W:0]   cnt_rd_data;
    logic                     Motion_Update_enable;
    logic                     MU_rden;
    logic [PARTICLE_ID_W-1:0] MU_rd_addr;
    full_cell_id_t            MU_rd_cell;
    logic                     mu_consume;
    logic                     MU_wr_data_valid;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, cnt_rd_data, mu_consume, MU_wr_data_valid,
        output cnt_rd_cell, cnt_rd_en, Motion_Update_enable, MU_rden, MU_rd_addr, MU_rd_cell,
               busy, done
    );

    modport slave (
        output start, cnt_rd_data, mu_consume, MU_wr_data_valid,
        input  cnt_rd_cell, cnt_rd_en, Motion_Update_enable, MU_rden, MU_rd_addr, MU_rd_cell,
               busy, done
    );

endinterface

// File: rtl/mu_credit_counter.sv
// Tracks free slots in the motion-update input FIFO; saturates at both ends.
module mu_credit_counter #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned W       = $clog2(CREDITS + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_i,
    input  logic         issue_i,
    input  logic         consume_i,
    output logic [W-1:0] credits_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_o <= W'(CREDITS);
        end else if (init_i) begin
            credits_o <= W'(CREDITS);
        end else if (consume_i && !issue_i && credits_o != W'(CREDITS)) begin
            credits_o <= credits_o + 1'b1;
        end else if (issue_i && !consume_i && credits_o != '0) begin
            credits_o <= credits_o - 1'b1;
        end
    end

endmodule

// File: rtl/pos_cache_mu_ctrl.sv
// Walks all cells, streams every cached particle into the motion-update unit under credit
// flow control, then waits for all write-backs before signalling completion.
module pos_cache_mu_ctrl
    import md_pkg::*;
#(
    parameter int unsigned NUM_CELLS             = 64,
    parameter int unsigned CELL_ID_WIDTH         = 3,
    parameter int unsigned PARTICLE_ID_WIDTH     = 7,
    parameter int unsigned NUM_PARTICLE_PER_CELL = 128,
    parameter int unsigned CREDITS               = 4
) (
    input logic                 clk,
    input logic                 rst,
    pos_cache_mu_ctrl_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(NUM_CELLS * NUM_PARTICLE_PER_CELL + 1);
    localparam int unsigned CRED_W = $clog2(CREDITS + 1);
    localparam int unsigned LIM_W  = PARTICLE_ID_WIDTH + 1;
    localparam logic [CELL_ID_WIDTH-1:0] AXIS_MAX = CELL_ID_WIDTH'(NUM_CELL_PER_AXIS);

    mu_ctrl_state_e    state_q;
    full_cell_id_t     ptr_q;
    full_cell_id_t     ptr_next;
    logic [LIM_W-1:0]  limit_q;
    logic [LIM_W-1:0]  addr_q;
    logic [CNT_W-1:0]  rd_total_q;
    logic [CNT_W-1:0]  wr_total_q;
    logic [CRED_W-1:0] credits;
    logic              init_credits;
    logic              issue;
    logic              last_cell;

    assign init_credits = (state_q == StIdle) && bus.start;
    // A credit returned this cycle can be spent by the read issued on the same edge.
    assign issue        = (state_q == StRead) && ((credits != '0) || bus.mu_consume);
    assign ptr_next     = next_cell(ptr_q);
    assign last_cell    = (ptr_q.x == AXIS_MAX) && (ptr_q.y == AXIS_MAX) && (ptr_q.z == AXIS_MAX);

    mu_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .init_i    (init_credits),
        .issue_i   (issue),
        .consume_i (bus.mu_consume),
        .credits_o (credits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q                  <= StIdle;
            ptr_q                    <= FIRST_CELL;
            limit_q                  <= '0;
            addr_q                   <= '0;
            rd_total_q               <= '0;
            wr_total_q               <= '0;
            bus.cnt_rd_cell          <= FIRST_CELL;
            bus.cnt_rd_en            <= 1'b0;
            bus.Motion_Update_enable <= 1'b0;
            bus.MU_rden              <= 1'b0;
            bus.MU_rd_addr           <= '0;
            bus.MU_rd_cell           <= FIRST_CELL;
            bus.busy                 <= 1'b0;
            bus.done                 <= 1'b0;
        end else begin
            bus.cnt_rd_en <= 1'b0;
            bus.MU_rden   <= 1'b0;
            bus.done      <= 1'b0;

            if (state_q != StIdle && bus.MU_wr_data_valid) begin
                wr_total_q <= wr_total_q + 1'b1;
            end
            if (issue) begin
                rd_total_q <= rd_total_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        ptr_q                    <= FIRST_CELL;
                        rd_total_q               <= '0;
                        wr_total_q               <= '0;
                        bus.cnt_rd_en            <= 1'b1;
                        bus.cnt_rd_cell          <= FIRST_CELL;
                        bus.Motion_Update_enable <= 1'b1;
                        bus.busy                 <= 1'b1;
                        state_q                  <= StCntReq;
                    end
                end
                StCntReq: begin
                    state_q <= StCntWait;
                end
                StCntWait: begin
                    limit_q <= bus.cnt_rd_data;
                    addr_q  <= '0;
                    state_q <= (bus.cnt_rd_data == '0) ? StNextCell : StRead;
                end
                StRead: begin
                    if (issue) begin
                        bus.MU_rden    <= 1'b1;
                        bus.MU_rd_addr <= addr_q[PARTICLE_ID_WIDTH-1:0];
                        bus.MU_rd_cell <= ptr_q;
                        addr_q         <= addr_q + 1'b1;
                        if (addr_q == limit_q - 1'b1) begin
                            state_q <= StNextCell;
                        end
                    end
                end
                StNextCell: begin
                    ptr_q <= ptr_next;
                    if (last_cell) begin
                        state_q <= StDrain;
                    end else begin
                        bus.cnt_rd_en   <= 1'b1;
                        bus.cnt_rd_cell <= ptr_next;
                        state_q         <= StCntReq;
                    end
                end
                StDrain: begin
                    if (wr_total_q == rd_total_q) begin
                        bus.done <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    bus.Motion_Update_enable <= 1'b0;
                    bus.busy                 <= 1'b0;
                    state_q                  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pos_cache_mu_ctrl.sv
// Directed bench for pos_cache_mu_ctrl with a count-memory model and a scripted MU unit.
module tb_pos_cache_mu_ctrl;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pos_cache_mu_ctrl_if bus ();

    pos_cache_mu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int counts [64];

    // MU-side behaviour knobs, written only by the tests.
    bit auto_consume   = 1'b0;
    bit auto_write     = 1'b0;
    bit stop_at_last   = 1'b0;
    bit manual_consume = 1'b0;
    bit manual_write   = 1'b0;
    int epoch          = 0;

    // Observation state, written only by the monitor.
    int            seen_epoch     = 0;
    int            cyc            = 0;
    int            n_lookup       = 0;
    int            n_reads        = 0;
    int            n_done         = 0;
    int            n_writes       = 0;
    int            writes_at_done = 0;
    int            pending        = 0;
    int            cons_cyc       = 0;
    bit            consume_off    = 1'b0;
    full_cell_id_t lookup_log [128];
    int            addr_log   [256];
    full_cell_id_t cell_log   [256];
    int            read_cyc   [256];

    function automatic full_cell_id_t mk(input int x, input int y, input int z);
        full_cell_id_t c;
        c.x = CELL_ID_W'(x);
        c.y = CELL_ID_W'(y);
        c.z = CELL_ID_W'(z);
        return c;
    endfunction

    function automatic int cidx(input full_cell_id_t c);
        return (int'(c.z) - 1) * 16 + (int'(c.y) - 1) * 4 + (int'(c.x) - 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Count memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.cnt_rd_en) begin
            if (cidx(bus.cnt_rd_cell) >= 0 && cidx(bus.cnt_rd_cell) < 64)
                bus.cnt_rd_data <= (PARTICLE_ID_W + 1)'(counts[cidx(bus.cnt_rd_cell)]);
            else
                bus.cnt_rd_data <= '0;
        end
    end

    // Monitor then MU driver, both on the falling edge.
    always @(negedge clk) begin
        bit wr;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            n_lookup   = 0;
            n_reads    = 0;
            n_done     = 0;
            n_writes   = 0;
            pending    = 0;
        end
        if (rst) pending = 0;
        if (!stop_at_last) consume_off = 1'b0;
        if (bus.cnt_rd_en) begin
            if (n_lookup < 128) lookup_log[n_lookup] = bus.cnt_rd_cell;
            n_lookup++;
            if (stop_at_last && bus.cnt_rd_cell == mk(4, 4, 4)) consume_off = 1'b1;
        end
        if (bus.MU_rden) begin
            if (n_reads < 256) begin
                addr_log[n_reads] = int'(bus.MU_rd_addr);
                cell_log[n_reads] = bus.MU_rd_cell;
                read_cyc[n_reads] = cyc;
            end
            n_reads++;
            pending++;
        end
        if (bus.done) begin
            n_done++;
            writes_at_done = n_writes;
        end
        bus.mu_consume = (auto_consume && !consume_off) || manual_consume;
        if (bus.mu_consume) cons_cyc = cyc;
        wr = manual_write || (auto_write && pending > 0);
        if (!manual_write && auto_write && pending > 0) pending--;
        bus.MU_wr_data_valid = wr;
        if (wr) n_writes++;
    end

    task automatic clear_logs();
        epoch++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_counts_zero();
        for (int i = 0; i < 64; i++) counts[i] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.Motion_Update_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mue: got %b want 0", bus.Motion_Update_enable); end
        n_checks++; if (bus.MU_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden: got %b want 0", bus.MU_rden); end
        n_checks++; if (bus.cnt_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", bus.cnt_rd_en); end
        n_checks++; if (bus.MU_rd_addr !== 7'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.MU_rd_addr); end
        n_checks++; if (bus.MU_rd_cell !== mk(1, 1, 1)) begin n_fail++; $display("FAIL reset_rd_cell: got %h want %h", bus.MU_rd_cell, mk(1, 1, 1)); end
        n_checks++; if (bus.cnt_rd_cell !== mk(1, 1, 1)) begin n_fail++; $display("FAIL reset_cnt_cell: got %h want %h", bus.cnt_rd_cell, mk(1, 1, 1)); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_zero();
        bit ok;
        set_counts_zero();
        auto_consume = 1'b1;
        auto_write   = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zero_timeout: done seen %b want 1", ok); end
        n_checks++; if (n_lookup != 64) begin n_fail++; $display("FAIL zero_lookups: got %0d want 64", n_lookup); end
        n_checks++; if (n_reads != 0) begin n_fail++; $display("FAIL zero_reads: got %0d want 0", n_reads); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", n_done); end
        n_checks++; if (bus.Motion_Update_enable !== 1'b0) begin n_fail++; $display("FAIL zero_mue_after: got %b want 0", bus.Motion_Update_enable); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after: got %b want 0", bus.busy); end
        n_checks++; if (lookup_log[0] !== mk(1, 1, 1)) begin n_fail++; $display("FAIL zero_order0: got %h want %h", lookup_log[0], mk(1, 1, 1)); end
        n_checks++; if (lookup_log[1] !== mk(2, 1, 1)) begin n_fail++; $display("FAIL zero_order1: got %h want %h", lookup_log[1], mk(2, 1, 1)); end
        n_checks++; if (lookup_log[4] !== mk(1, 2, 1)) begin n_fail++; $display("FAIL zero_order4: got %h want %h", lookup_log[4], mk(1, 2, 1)); end
        n_checks++; if (lookup_log[16] !== mk(1, 1, 2)) begin n_fail++; $display("FAIL zero_order16: got %h want %h", lookup_log[16], mk(1, 1, 2)); end
        n_checks++; if (lookup_log[63] !== mk(4, 4, 4)) begin n_fail++; $display("FAIL zero_order63: got %h want %h", lookup_log[63], mk(4, 4, 4)); end
    endtask

    task automatic test_single_cell();
        bit ok;
        set_counts_zero();
        counts[cidx(mk(2, 1, 1))] = 3;
        auto_consume = 1'b1;
        auto_write   = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: done seen %b want 1", ok); end
        n_checks++; if (n_reads != 3) begin n_fail++; $display("FAIL single_reads: got %0d want 3", n_reads); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (addr_log[i] != i) begin n_fail++; $display("FAIL single_addr%0d: got %0d want %0d", i, addr_log[i], i); end
            n_checks++; if (cell_log[i] !== mk(2, 1, 1)) begin n_fail++; $display("FAIL single_cell%0d: got %h want %h", i, cell_log[i], mk(2, 1, 1)); end
        end
        n_checks++; if (writes_at_done != 3) begin n_fail++; $display("FAIL single_writes_at_done: got %0d want 3", writes_at_done); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", n_done); end
    endtask

    task automatic test_stall();
        bit ok;
        set_counts_zero();
        counts[cidx(mk(1, 1, 1))] = 10;
        auto_consume = 1'b0;
        auto_write   = 1'b0;
        clear_logs();
        pulse_start();
        repeat (20) @(posedge clk);
        n_checks++; if (n_reads != 4) begin n_fail++; $display("FAIL stall_reads: got %0d want 4", n_reads); end
        n_checks++; if (addr_log[3] != 3) begin n_fail++; $display("FAIL stall_addr3: got %0d want 3", addr_log[3]); end
        @(posedge clk);
        manual_consume = 1'b1;
        @(posedge clk);
        manual_consume = 1'b0;
        repeat (10) @(posedge clk);
        n_checks++; if (n_reads != 5) begin n_fail++; $display("FAIL stall_one_more: got %0d want 5", n_reads); end
        n_checks++; if (addr_log[4] != 4) begin n_fail++; $display("FAIL stall_addr4: got %0d want 4", addr_log[4]); end
        n_checks++; if (read_cyc[4] - cons_cyc != 1) begin n_fail++; $display("FAIL stall_latency: got %0d want 1", read_cyc[4] - cons_cyc); end
        auto_consume = 1'b1;
        auto_write   = 1'b1;
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_timeout: done seen %b want 1", ok); end
        n_checks++; if (n_reads != 10) begin n_fail++; $display("FAIL stall_total: got %0d want 10", n_reads); end
        n_checks++; if (addr_log[9] != 9) begin n_fail++; $display("FAIL stall_addr9: got %0d want 9", addr_log[9]); end
    endtask

    task automatic test_credit_cap();
        bit ok;
        set_counts_zero();
        counts[cidx(mk(4, 4, 4))] = 10;
        auto_consume = 1'b1;
        stop_at_last = 1'b1;
        auto_write   = 1'b0;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 2000 && n_lookup < 64; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        n_checks++; if (n_reads != 4) begin n_fail++; $display("FAIL cap_reads: got %0d want 4", n_reads); end
        stop_at_last = 1'b0;
        auto_write   = 1'b1;
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cap_timeout: done seen %b want 1", ok); end
        n_checks++; if (n_reads != 10) begin n_fail++; $display("FAIL cap_total: got %0d want 10", n_reads); end
    endtask

    task automatic test_full_cell();
        bit ok;
        int bad_addr;
        int bad_cell;
        set_counts_zero();
        counts[cidx(mk(4, 4, 4))] = 128;
        auto_consume = 1'b1;
        auto_write   = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_timeout: done seen %b want 1", ok); end
        n_checks++; if (n_reads != 128) begin n_fail++; $display("FAIL full_reads: got %0d want 128", n_reads); end
        bad_addr = 0;
        bad_cell = 0;
        for (int i = 0; i < 128; i++) begin
            if (addr_log[i] != i) bad_addr++;
            if (cell_log[i] !== mk(4, 4, 4)) bad_cell++;
        end
        n_checks++; if (bad_addr != 0) begin n_fail++; $display("FAIL full_addr_seq: %0d wrong addresses, want 0", bad_addr); end
        n_checks++; if (bad_cell != 0) begin n_fail++; $display("FAIL full_cell_seq: %0d wrong cells, want 0", bad_cell); end
        n_checks++; if (read_cyc[127] - read_cyc[0] != 127) begin n_fail++; $display("FAIL full_back_to_back: span %0d want 127", read_cyc[127] - read_cyc[0]); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", n_done); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        set_counts_zero();
        counts[cidx(mk(1, 1, 1))] = 10;
        auto_consume = 1'b1;
        auto_write   = 1'b1;
        clear_logs();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.MU_rden === 1'b1 && bus.MU_rd_addr === 7'd5) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rmid_reach_addr5: got %b want 1", hit); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.MU_rden !== 1'b0) begin n_fail++; $display("FAIL rmid_rden: got %b want 0", bus.MU_rden); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.Motion_Update_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_mue: got %b want 0", bus.Motion_Update_enable); end
        n_checks++; if (bus.MU_rd_addr !== 7'd0) begin n_fail++; $display("FAIL rmid_addr: got %0d want 0", bus.MU_rd_addr); end
        n_checks++; if (bus.MU_rd_cell !== mk(1, 1, 1)) begin n_fail++; $display("FAIL rmid_rd_cell: got %h want %h", bus.MU_rd_cell, mk(1, 1, 1)); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want 0", n_done); end
        clear_logs();
        pulse_start();
        wait_done(3000, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_timeout: done seen %b want 1", ok); end
        n_checks++; if (lookup_log[0] !== mk(1, 1, 1)) begin n_fail++; $display("FAIL rmid_restart_cell: got %h want %h", lookup_log[0], mk(1, 1, 1)); end
        n_checks++; if (addr_log[0] != 0) begin n_fail++; $display("FAIL rmid_restart_addr: got %0d want 0", addr_log[0]); end
        n_checks++; if (n_reads != 10) begin n_fail++; $display("FAIL rmid_total: got %0d want 10", n_reads); end
    endtask

    task automatic test_drain();
        bit ok;
        set_counts_zero();
        counts[cidx(mk(1, 1, 1))] = 3;
        counts[cidx(mk(3, 2, 1))] = 2;
        auto_consume = 1'b1;
        auto_write   = 1'b0;
        clear_logs();
        pulse_start();
        repeat (300) @(posedge clk);
        n_checks++; if (n_reads != 5) begin n_fail++; $display("FAIL drain_reads: got %0d want 5", n_reads); end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL drain_early_done: got %0d want 0", n_done); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", bus.busy); end
        pulse_start();
        repeat (5) @(posedge clk);
        n_checks++; if (n_lookup != 64) begin n_fail++; $display("FAIL drain_start_ignored: got %0d lookups want 64", n_lookup); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            manual_write = 1'b1;
            @(posedge clk);
            manual_write = 1'b0;
        end
        repeat (5) @(posedge clk);
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL drain_done_at_4: got %0d want 0", n_done); end
        @(posedge clk);
        manual_write = 1'b1;
        @(posedge clk);
        manual_write = 1'b0;
        wait_done(50, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL drain_timeout: done seen %b want 1", ok); end
        n_checks++; if (writes_at_done != 5) begin n_fail++; $display("FAIL drain_writes_at_done: got %0d want 5", writes_at_done); end
        n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL drain_done_count: got %0d want 1", n_done); end
    endtask

    initial begin
        bus.start = 1'b0;
        set_counts_zero();
        test_reset();
        test_all_zero();
        test_single_cell();
        test_stall();
        test_credit_cap();
        test_full_cell();
        test_reset_mid();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
